// File: rtl/rs232_tx_chan.sv
// rs232_tx_chan: transmit half of one RS232 channel.
// Bytes enter a small FIFO over a load/ok_2_ld handshake and are serialised 8N1
// (start bit, D_W data bits LSB first, one stop bit) at a runtime baud divisor.
module rs232_tx_chan #(
    parameter int unsigned D_W        = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_DIV_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [MAX_DIV_W-1:0] baud_div,
    input  logic [D_W-1:0]       data_in,
    input  logic                 load,
    output logic                 ok_2_ld,
    output logic                 RS232_TX,
    output logic                 busy,
    output logic                 overflow,
    input  logic                 clear_flags
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BW = (D_W > 1) ? $clog2(D_W) : 1;

    localparam logic [BW-1:0]        LastBit = BW'(D_W - 1);
    localparam logic [MAX_DIV_W-1:0] MinDiv  = MAX_DIV_W'(2);
    localparam logic [MAX_DIV_W-1:0] OneDiv  = MAX_DIV_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [D_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [D_W-1:0] head;

    logic           overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    state_e               state_q;
    logic                 tx_q;
    logic [D_W-1:0]       shift_q;
    logic [D_W-1:0]       shift_nxt;
    logic [MAX_DIV_W-1:0] div_q;
    logic [MAX_DIV_W-1:0] baud_cnt_q;
    logic [MAX_DIV_W-1:0] div_eff;
    logic [BW-1:0]        bit_cnt_q;
    logic                 baud_wrap;
    logic                 start_frame;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Depends only on registered state and enable, never on load.
    assign ok_2_ld = enable & ~full;
    assign push    = load & ok_2_ld;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Divisors below 2 are clamped so every bit lasts at least two cycles.
    assign div_eff = (baud_div < MinDiv) ? MinDiv : baud_div;

    assign baud_wrap = (baud_cnt_q == (div_q - OneDiv));
    assign shift_nxt = shift_q >> 1;

    // A new frame begins from idle, or straight out of a finished stop bit.
    assign start_frame = enable & ~empty &
                         ((state_q == StIdle) || ((state_q == StStop) && baud_wrap));
    assign pop = start_frame;

    // Next-state for FIFO pointers and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW + 1)'(pop);
        overflow_d = overflow_q;
        if (clear_flags) begin
            overflow_d = 1'b0;
        end
        // A dropped load wins over a simultaneous clear.
        if (load && !ok_2_ld) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO data array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    // FIFO pointers and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame FSM with registered line output; divisor is latched per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            div_q      <= MinDiv;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (start_frame) begin
                        state_q    <= StStart;
                        tx_q       <= 1'b0;
                        shift_q    <= head;
                        div_q      <= div_eff;
                        baud_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (baud_wrap) begin
                        state_q    <= StData;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + OneDiv;
                    end
                end
                StData: begin
                    if (baud_wrap) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == LastBit) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            shift_q   <= shift_nxt;
                            tx_q      <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + OneDiv;
                    end
                end
                StStop: begin
                    if (baud_wrap) begin
                        baud_cnt_q <= '0;
                        if (start_frame) begin
                            // Back-to-back frame: no idle cycle between stop and start.
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                            shift_q <= head;
                            div_q   <= div_eff;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + OneDiv;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign RS232_TX = tx_q;
    assign busy     = (state_q != StIdle) | ~empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rs232_tx_chan.sv
// tb_rs232_tx_chan: self-checking bench for rs232_tx_chan.
// The reference model is a frame schedule (load edge, start edge, divisor, byte per
// frame); the expected line level, busy and FIFO occupancy at any cycle are derived
// from that schedule with plain arithmetic.
module tb_rs232_tx_chan;

    localparam int D_W   = 8;
    localparam int DEPTH = 4;
    localparam int FLEN  = D_W + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [7:0]  data_in = 8'h00;
    logic        load = 1'b0;
    logic        clear_flags = 1'b0;
    logic        ok_2_ld;
    logic        RS232_TX;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Frame schedule used by the model.
    int         n_fr;
    int         fr_load  [8];
    int         fr_start [8];
    int         fr_div   [8];
    logic [7:0] fr_byte  [8];

    always #5 clk = ~clk;

    rs232_tx_chan #(
        .D_W        (8),
        .FIFO_DEPTH (4),
        .MAX_DIV_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .baud_div    (baud_div),
        .data_in     (data_in),
        .load        (load),
        .ok_2_ld     (ok_2_ld),
        .RS232_TX    (RS232_TX),
        .busy        (busy),
        .overflow    (overflow),
        .clear_flags (clear_flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        load        = 1'b0;
        clear_flags = 1'b0;
        enable      = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Line level just after edge t.
    function automatic logic model_tx(int t);
        for (int i = 0; i < n_fr; i++) begin
            if (t >= fr_start[i] && t < fr_start[i] + FLEN * fr_div[i]) begin
                int k;
                k = (t - fr_start[i]) / fr_div[i];
                if (k == 0) return 1'b0;
                if (k == FLEN - 1) return 1'b1;
                return fr_byte[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    // A byte keeps the channel busy from its load edge until its frame ends.
    function automatic logic model_busy(int t);
        for (int i = 0; i < n_fr; i++) begin
            if (fr_load[i] <= t && t < fr_start[i] + FLEN * fr_div[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Bytes held in the FIFO just after edge t.
    function automatic int model_count(int t);
        int c;
        c = 0;
        for (int i = 0; i < n_fr; i++) begin
            if (fr_load[i] <= t) c++;
            if (fr_start[i] <= t) c--;
        end
        return c;
    endfunction

    function automatic int clamp_div(int d);
        return (d < 2) ? 2 : d;
    endfunction

    // With enable held high, a frame starts one edge after its load or as soon as
    // the previous frame ends, whichever is later.
    function automatic void plan_frames();
        for (int i = 0; i < n_fr; i++) begin
            fr_start[i] = fr_load[i] + 1;
            if (i > 0 && fr_start[i-1] + FLEN * fr_div[i-1] > fr_start[i]) begin
                fr_start[i] = fr_start[i-1] + FLEN * fr_div[i-1];
            end
        end
    endfunction

    function automatic int sched_end();
        return fr_start[n_fr-1] + FLEN * fr_div[n_fr-1];
    endfunction

    function automatic void drive_loads(int t);
        load    = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < n_fr; i++) begin
            if (fr_load[i] == t) begin
                load    = 1'b1;
                data_in = fr_byte[i];
            end
        end
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        repeat (2) tick();
        checks++;
        if (RS232_TX !== 1'b1) begin
            errors++; $display("FAIL reset_tx got %b exp 1", RS232_TX);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", busy);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got %b exp 0", overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (ok_2_ld !== 1'b0) begin
            errors++; $display("FAIL reset_ok_dis got %b exp 0", ok_2_ld);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (ok_2_ld !== 1'b1) begin
            errors++; $display("FAIL reset_ok_en got %b exp 1", ok_2_ld);
        end
        tick();
        checks++;
        if (RS232_TX !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle got tx=%b busy=%b exp tx=1 busy=0",
                               RS232_TX, busy);
        end
    endtask

    task automatic test_single();
        int tend;
        do_reset();
        baud_div   = 16'd4;
        n_fr       = 1;
        fr_load[0] = 0;
        fr_byte[0] = 8'h55;
        fr_div[0]  = 4;
        plan_frames();
        tend = sched_end();
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            #1;
            checks++;
            if (ok_2_ld !== (model_count(t - 1) < DEPTH)) begin
                errors++; $display("FAIL single_ok t=%0d got %b", t, ok_2_ld);
            end
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL single_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
            checks++;
            if (busy !== model_busy(t)) begin
                errors++; $display("FAIL single_busy t=%0d got %b exp %b", t, busy,
                                   model_busy(t));
            end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int tend;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
        do_reset();
        baud_div = 16'd3;
        n_fr     = 4;
        for (int i = 0; i < 4; i++) begin
            fr_load[i] = i;
            fr_byte[i] = bytes[i];
            fr_div[i]  = 3;
        end
        plan_frames();
        tend = sched_end();
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            #1;
            checks++;
            if (ok_2_ld !== (model_count(t - 1) < DEPTH)) begin
                errors++; $display("FAIL b2b_ok t=%0d got %b", t, ok_2_ld);
            end
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL b2b_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
            checks++;
            if (busy !== model_busy(t)) begin
                errors++; $display("FAIL b2b_busy t=%0d got %b exp %b", t, busy,
                                   model_busy(t));
            end
        end
        load = 1'b0;
    endtask

    task automatic test_overflow();
        int   tend;
        logic exp_ovf;
        do_reset();
        baud_div = 16'd4;
        n_fr     = 5;
        for (int i = 0; i < 5; i++) begin
            fr_load[i] = i;
            fr_byte[i] = 8'($urandom_range(0, 255));
            fr_div[i]  = 4;
        end
        plan_frames();
        tend    = sched_end();
        exp_ovf = 1'b0;
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            clear_flags = 1'b0;
            // Loads into a full FIFO; t=41 coincides with a pop and must still drop.
            if (t == 5 || t == 6 || t == 41) begin
                load    = 1'b1;
                data_in = 8'hEE;
            end
            if (t == 6 || t == 7) clear_flags = 1'b1;
            #1;
            checks++;
            if (ok_2_ld !== (model_count(t - 1) < DEPTH)) begin
                errors++; $display("FAIL ovf_ok t=%0d got %b exp %b", t, ok_2_ld,
                                   model_count(t - 1) < DEPTH);
            end
            if (load && (model_count(t - 1) >= DEPTH)) exp_ovf = 1'b1;
            else if (clear_flags) exp_ovf = 1'b0;
            tick();
            checks++;
            if (overflow !== exp_ovf) begin
                errors++; $display("FAIL ovf_flag t=%0d got %b exp %b", t, overflow, exp_ovf);
            end
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL ovf_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
        end
        load        = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic test_divisor();
        int tend;
        // Divisor 0 clamps to 2-cycle bits.
        do_reset();
        baud_div   = 16'd0;
        n_fr       = 1;
        fr_load[0] = 0;
        fr_byte[0] = 8'($urandom_range(0, 255));
        fr_div[0]  = clamp_div(0);
        plan_frames();
        tend = sched_end();
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL div0_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
        end
        // Divisor changed mid-frame only affects the following frame.
        baud_div   = 16'd8;
        n_fr       = 2;
        fr_load[0] = 0;
        fr_load[1] = 1;
        fr_byte[0] = 8'($urandom_range(0, 255));
        fr_byte[1] = 8'($urandom_range(0, 255));
        fr_div[0]  = 8;
        fr_div[1]  = 16;
        plan_frames();
        tend = sched_end();
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            if (t == 30) baud_div = 16'd16;
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL divlatch_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
            checks++;
            if (busy !== model_busy(t)) begin
                errors++; $display("FAIL divlatch_busy t=%0d got %b exp %b", t, busy,
                                   model_busy(t));
            end
        end
        load = 1'b0;
    endtask

    task automatic test_enable_drop();
        int   tend;
        logic en;
        do_reset();
        baud_div = 16'd4;
        n_fr     = 3;
        fr_byte[0] = 8'h81;
        fr_byte[1] = 8'($urandom_range(0, 255));
        fr_byte[2] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) begin
            fr_load[i] = i;
            fr_div[i]  = 4;
        end
        // Enable is low over edges 18..49: frame 0 finishes, frame 1 waits for edge 50.
        fr_start[0] = 1;
        fr_start[1] = 50;
        fr_start[2] = fr_start[1] + FLEN * 4;
        tend = sched_end();
        for (int t = 0; t <= tend + 2; t++) begin
            drive_loads(t);
            en     = !(t >= 18 && t < 50);
            enable = en;
            #1;
            checks++;
            if (ok_2_ld !== (en && (model_count(t - 1) < DEPTH))) begin
                errors++; $display("FAIL endrop_ok t=%0d got %b exp %b", t, ok_2_ld,
                                   en && (model_count(t - 1) < DEPTH));
            end
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL endrop_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
            checks++;
            if (busy !== model_busy(t)) begin
                errors++; $display("FAIL endrop_busy t=%0d got %b exp %b", t, busy,
                                   model_busy(t));
            end
        end
        load   = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        baud_div   = 16'd4;
        n_fr       = 2;
        fr_load[0] = 0;
        fr_load[1] = 1;
        fr_byte[0] = 8'h5A;
        fr_byte[1] = 8'h33;
        fr_div[0]  = 4;
        fr_div[1]  = 4;
        plan_frames();
        for (int t = 0; t <= 6; t++) begin
            drive_loads(t);
            enable = 1'b1;
            if (t == 3) begin
                // Load while disabled raises overflow before the reset hits.
                enable  = 1'b0;
                load    = 1'b1;
                data_in = 8'hEE;
            end
            tick();
            checks++;
            if (RS232_TX !== model_tx(t)) begin
                errors++; $display("FAIL arst_pre_tx t=%0d got %b exp %b", t, RS232_TX,
                                   model_tx(t));
            end
        end
        load = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL arst_pre_ovf got %b exp 1", overflow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (RS232_TX !== 1'b1) begin
            errors++; $display("FAIL arst_tx got %b exp 1", RS232_TX);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL arst_busy got %b exp 0", busy);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL arst_ovf got %b exp 0", overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            checks++;
            if (RS232_TX !== 1'b1 || busy !== 1'b0 || ok_2_ld !== 1'b1) begin
                errors++;
                $display("FAIL arst_post t=%0d got tx=%b busy=%b ok=%b exp 1 0 1",
                         t, RS232_TX, busy, ok_2_ld);
            end
        end
    endtask

    task automatic test_random();
        int tend;
        int d;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            d        = int'($urandom_range(0, 6));
            baud_div = 16'(d);
            n_fr     = int'($urandom_range(1, 5));
            for (int i = 0; i < n_fr; i++) begin
                fr_load[i] = (i == 0) ? 0 : fr_load[i-1] + 1 + int'($urandom_range(0, 12));
                fr_byte[i] = 8'($urandom_range(0, 255));
                fr_div[i]  = clamp_div(d);
            end
            plan_frames();
            tend = sched_end();
            for (int t = 0; t <= tend + 2; t++) begin
                drive_loads(t);
                #1;
                checks++;
                if (ok_2_ld !== (model_count(t - 1) < DEPTH)) begin
                    errors++; $display("FAIL rnd_ok it=%0d t=%0d got %b", it, t, ok_2_ld);
                end
                tick();
                checks++;
                if (RS232_TX !== model_tx(t)) begin
                    errors++; $display("FAIL rnd_tx it=%0d t=%0d got %b exp %b", it, t,
                                       RS232_TX, model_tx(t));
                end
                checks++;
                if (busy !== model_busy(t)) begin
                    errors++; $display("FAIL rnd_busy it=%0d t=%0d got %b exp %b", it, t,
                                       busy, model_busy(t));
                end
            end
            load = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_divisor();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
